inst_rom_resp: RTL and testbench
================================

# inst_rom_resp

Instruction-memory responder for the fetch stage: the read side of the fetch interface whose initiator drives a byte PC and a chip-enable every cycle. It samples `ce`/`addr` on each clock edge and returns the addressed 32-bit instruction, registered, one cycle later with a valid flag. Misaligned or out-of-range fetches are flagged. A load port lets the bench or boot logic fill the array, including while the core is held in reset.

## Interface

Parameters:
- DEPTH_LOG2, 10: log2 of the word count; the array holds 2^DEPTH_LOG2 32-bit words.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- rst  in  1  reset, synchronous and active-low (asserted when 0).
- ce  in  1  fetch request enable from the PC stage (1 = fetch).
- addr  in  32  fetch byte address (the PC).
- ld_en  in  1  load-port write enable.
- ld_addr  in  32  load byte address.
- ld_data  in  INST_W  load data.
- inst  out  INST_W  registered instruction.
- inst_valid  out  1  `inst` holds a response to an accepted fetch.
- addr_err  out  1  the accepted fetch was misaligned or out of range.
- fetch_cnt  out  32  saturating count of accepted fetches.

## Operation

- Word index: addr[DEPTH_LOG2+1:2].
- In range: addr[31:DEPTH_LOG2+2] == 0.
- Aligned: addr[1:0] == 0.
- Reset (rst == 0 at posedge):
  - inst = 0, inst_valid = 0, addr_err = 0, fetch_cnt = 0.
  - Array contents are not cleared.
  - Fetches are ignored.
- Fetch, accepted when rst == 1 and ce == 1 at posedge:
  - inst_valid <= 1.
  - Aligned and in range: inst <= mem[index], addr_err <= 0.
  - Otherwise: inst <= 0 (NOP), addr_err <= 1. The array is not read.
  - fetch_cnt <= fetch_cnt + 1, saturating at 0xFFFF_FFFF. A fetch flagged by addr_err is still counted.
- Idle, when rst == 1 and ce == 0 at posedge:
  - inst <= 0, inst_valid <= 0, addr_err <= 0.
  - fetch_cnt holds.
- Load, when ld_en == 1 at posedge:
  - Writes mem[ld_addr index] <= ld_data if ld_addr is aligned and in range. Otherwise the write is silently dropped.
  - Loads are accepted regardless of rst, so a program can be loaded while the core is held in reset.
- Same-cycle load and fetch to the same word index: write-first. The fetch returns ld_data, and the array holds ld_data afterward.
- Same-cycle load and fetch to different indices: independent, with no interaction.
- No backpressure. Every accepted fetch produces exactly one response on the next cycle.
- There is no internal state machine beyond the response register stage and the counter. The response stage has two states, IDLE (inst_valid = 0) and RESP (inst_valid = 1), selected solely by the sampled ce and rst.

## Timing

- Latency: exactly 1 cycle. If ce/addr are sampled at edge N, then inst, inst_valid and addr_err are valid from just after edge N until edge N+1.
- Throughput: one fetch per cycle. Back-to-back addresses 0, 4, 8 yield a continuous inst stream with inst_valid held high.
- Reset mid-stream: at the first edge with rst == 0, all outputs are 0. At the first edge with rst == 1 and ce == 1, the response appears 1 cycle later. No response from before reset is ever emitted after reset.
- Reset deassertion with ce == 0 keeps the outputs at reset values until ce rises.
- Load latency: data written at edge N is visible to a fetch sampled at edge N (write-first) or at any later edge.
- fetch_cnt updates on the same edge as the response it counts.
- fetch_cnt at 0xFFFF_FFFF stays at 0xFFFF_FFFF; it never wraps.
- All outputs are driven only from registers. There is no combinational path from inputs to outputs.

## Test plan

- Load and stream:
  - Stimulus: rst = 0, load words 0x11111111, 0x22222222, 0x33333333 at byte addresses 0, 4, 8. Release rst, then apply ce = 1 with addr 0, 4, 8 on consecutive cycles.
  - Required response: inst = 0x11111111, 0x22222222, 0x33333333 on the following cycles, inst_valid = 1 throughout, addr_err = 0, fetch_cnt = 3.
- Misaligned and out-of-range fetch:
  - Stimulus: fetch at addr 0x2, then at addr 0x1000 (DEPTH_LOG2 = 10).
  - Required response: each returns inst = 0, inst_valid = 1, addr_err = 1, and fetch_cnt increments. A load to 0x1000 leaves mem[0] unchanged.
- Write-first collision:
  - Stimulus: mem[1] = 0xAAAA0000. At the same edge, ld_en with ld_addr = 4, ld_data = 0xBEEF0001, and fetch addr = 4.
  - Required response: inst = 0xBEEF0001. A later fetch of 4 returns 0xBEEF0001.
- Idle and reset mid-stream:
  - Stimulus: stream fetches, drop ce for 2 cycles, then pull rst low for 1 cycle mid-stream.
  - Required response: when ce drops, inst = 0, inst_valid = 0, fetch_cnt holds. The cycle after the reset edge, all outputs are 0. Memory contents are preserved: refetching addr 0 returns 0x11111111.
- Counter saturation:
  - Stimulus: force or preload fetch_cnt to 0xFFFF_FFFE, then issue 3 fetches.
  - Required response: fetch_cnt reads 0xFFFF_FFFF, then 0xFFFF_FFFF, then 0xFFFF_FFFF.
- Handoff from PC stage:
  - Stimulus: pair with the PC stage (pc starts at 0, +4 per cycle). Preload mem[k] = k for k = 0..15.
  - Required response: the inst sequence is 0, 1, 2, … with one-cycle lag after ce rises.

Source files
------------

// File: rtl/inst_rom_resp_if.sv
// Fetch-side bus of the instruction ROM responder.
// master = PC stage / boot loader; slave = the ROM responder.
interface inst_rom_resp_if #(
  parameter int INST_W = 32
);
  // Fetch request, sampled by the responder on every clock edge.
  logic              ce;
  logic [31:0]       addr;
  // Load port used to fill the array.
  logic              ld_en;
  logic [31:0]       ld_addr;
  logic [INST_W-1:0] ld_data;
  // Registered response.
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              addr_err;
  logic [31:0]       fetch_cnt;

  modport master (
    output ce, addr, ld_en, ld_addr, ld_data,
    input  inst, inst_valid, addr_err, fetch_cnt
  );

  modport slave (
    input  ce, addr, ld_en, ld_addr, ld_data,
    output inst, inst_valid, addr_err, fetch_cnt
  );
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder for the fetch stage.
//
// Handshake: there is no backpressure. A fetch is accepted on any posedge
// where rst == 1 and ce == 1; its response (inst, addr_err) is presented
// with inst_valid == 1 for exactly the following cycle. inst_valid == 0
// means inst and addr_err are 0 and carry no response.
//
// A fetch is good when addr is word aligned and addr[31:DEPTH_LOG2+2] is
// zero; otherwise a NOP (0) is returned with addr_err set. Loads write the
// array regardless of rst; a load and fetch to the same word in the same
// cycle return the load data (write-first).
module inst_rom_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int INST_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_rom_resp_if.slave        bus,
  output logic                  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } resp_state_e;

  resp_state_e state_q, state_d;

  logic [INST_W-1:0]     mem_q [DEPTH];

  logic [INST_W-1:0]     inst_q, inst_d;
  logic                  addr_err_q, addr_err_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_ok;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic                  ld_ok;
  logic                  wr_hit;
  logic [INST_W-1:0]     rd_data;

  // Decode fetch and load addresses; resolve write-first forwarding.
  always_comb begin
    rd_idx  = bus.addr[DEPTH_LOG2+1:2];
    rd_ok   = (bus.addr[1:0] == 2'b00) && (bus.addr[31:DEPTH_LOG2+2] == '0);
    ld_idx  = bus.ld_addr[DEPTH_LOG2+1:2];
    ld_ok   = bus.ld_en && (bus.ld_addr[1:0] == 2'b00) &&
              (bus.ld_addr[31:DEPTH_LOG2+2] == '0);
    wr_hit  = ld_ok && (ld_idx == rd_idx);
    rd_data = wr_hit ? bus.ld_data : mem_q[rd_idx];
  end

  // Array write; contents survive reset so a program can be loaded under reset.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem_q[ld_idx] <= bus.ld_data;
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next response state: RESP exactly when a fetch is accepted.
  always_comb begin
    state_d = S_IDLE;
    if (bus.ce) begin
      state_d = S_RESP;
    end
  end

  // Next response payload and saturating fetch counter.
  always_comb begin
    inst_d      = '0;
    addr_err_d  = 1'b0;
    fetch_cnt_d = fetch_cnt_q;
    if (bus.ce) begin
      if (rd_ok) begin
        inst_d = rd_data;
      end else begin
        addr_err_d = 1'b1;
      end
      if (fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  // Response payload and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q      <= '0;
      addr_err_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      inst_q      <= inst_d;
      addr_err_q  <= addr_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.inst       = inst_q;
    bus.inst_valid = (state_q == S_RESP);
    bus.addr_err   = addr_err_q;
    bus.fetch_cnt  = fetch_cnt_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: a driver pushes the hand-computed
// response for each cycle into exp_q; a monitor pops and compares it one
// cycle later.
module tb_inst_rom_resp;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_rom_resp_if #(.INST_W(32)) bus ();

  inst_rom_resp #(
    .DEPTH_LOG2(10),
    .INST_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Packed expectation: {inst[31:0], valid, err, cnt[31:0]}.
  logic [65:0] exp_q[$];
  logic [65:0] e;
  int checks   = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare the response registered at each posedge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk32("inst",       bus.inst,       e[65:34]);
      chk1 ("inst_valid", bus.inst_valid, e[33]);
      chk1 ("addr_err",   bus.addr_err,   e[32]);
      chk32("fetch_cnt",  bus.fetch_cnt,  e[31:0]);
      chk1 ("dbg_state",  dbg_state,      e[33]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic c, input logic [31:0] a,
                       input logic le, input logic [31:0] la, input logic [31:0] ld,
                       input logic [31:0] ei, input logic ev, input logic ee,
                       input logic [31:0] ec);
    @(negedge clk);
    rst         = r;
    bus.ce      = c;
    bus.addr    = a;
    bus.ld_en   = le;
    bus.ld_addr = la;
    bus.ld_data = ld;
    exp_q.push_back({ei, ev, ee, ec});
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input logic ee, input logic [31:0] ec);
    drive(1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0, ei, 1'b1, ee, ec);
  endtask

  task automatic idle(input logic [31:0] ec);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, ec);
  endtask

  task automatic load_in_reset(input logic [31:0] la, input logic [31:0] ld);
    drive(1'b0, 1'b1, 32'h0, 1'b1, la, ld, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    bus.ce      = 1'b0;
    bus.addr    = 32'h0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = 32'h0;
    bus.ld_data = 32'h0;

    // Load under reset; the concurrent ce=1 must be ignored.
    load_in_reset(32'h0, 32'h1111_1111);
    load_in_reset(32'h4, 32'h2222_2222);
    load_in_reset(32'h8, 32'h3333_3333);

    // Back-to-back stream.
    fetch(32'h0, 32'h1111_1111, 1'b0, 32'd1);
    fetch(32'h4, 32'h2222_2222, 1'b0, 32'd2);
    fetch(32'h8, 32'h3333_3333, 1'b0, 32'd3);

    // ce dropped for two cycles: outputs clear, counter holds.
    idle(32'd3);
    idle(32'd3);

    // Misaligned and out-of-range fetches are counted and flagged.
    fetch(32'h2,    32'h0, 1'b1, 32'd4);
    fetch(32'h1000, 32'h0, 1'b1, 32'd5);
    // Out-of-range and misaligned loads are dropped.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'd5);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h5,    32'hCAFE_0005, 32'h0, 1'b0, 1'b0, 32'd5);
    fetch(32'h0, 32'h1111_1111, 1'b0, 32'd6);
    fetch(32'h4, 32'h2222_2222, 1'b0, 32'd7);

    // Write-first collision on word 1.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'hAAAA_0000, 32'h0, 1'b0, 1'b0, 32'd7);
    drive(1'b1, 1'b1, 32'h4, 1'b1, 32'h4, 32'hBEEF_0001, 32'hBEEF_0001, 1'b1, 1'b0, 32'd8);
    fetch(32'h4, 32'hBEEF_0001, 1'b0, 32'd9);
    // Load and fetch to different words in one cycle do not interact.
    drive(1'b1, 1'b1, 32'h8, 1'b1, 32'h10, 32'h5555_0010, 32'h3333_3333, 1'b1, 1'b0, 32'd10);
    fetch(32'h10, 32'h5555_0010, 1'b0, 32'd11);

    // Reset mid-stream; memory survives, counter restarts.
    fetch(32'h0, 32'h1111_1111, 1'b0, 32'd12);
    fetch(32'h8, 32'h3333_3333, 1'b0, 32'd13);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    idle(32'd0);
    fetch(32'h0, 32'h1111_1111, 1'b0, 32'd1);
    idle(32'd1);

    // Counter saturation: preload the counter just below its ceiling.
    @(posedge clk);
    #2;
    force dut.fetch_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt_q;
    fetch(32'h8, 32'h3333_3333, 1'b0, 32'hFFFF_FFFF);
    fetch(32'h8, 32'h3333_3333, 1'b0, 32'hFFFF_FFFF);
    fetch(32'h8, 32'h3333_3333, 1'b0, 32'hFFFF_FFFF);

    // Handoff from a PC stage: mem[k] = k, pc = 0, 4, 8, ...
    for (int k = 0; k < 16; k++) begin
      load_in_reset(32'(k * 4), 32'(k));
    end
    idle(32'd0);
    idle(32'd0);
    for (int k = 0; k < 16; k++) begin
      fetch(32'(k * 4), 32'(k), 1'b0, 32'(k + 1));
    end
    idle(32'd16);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
